// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - program memory write port driven by the UART boot loader
// Loader drives the master side; Program_Memory (or a bench monitor) takes the slave side.
interface uart_program_loader_if #(
    parameter int AB = 11,
    parameter int DB = 16
) ();
    logic          pm_we;
    logic [AB-1:0] pm_addr;
    logic [DB-1:0] pm_wdata;

    modport master (output pm_we, output pm_addr, output pm_wdata);
    modport slave  (input  pm_we, input  pm_addr, input  pm_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - 8N1 serial boot loader writing 16-bit words into program memory
// Optional trailing XOR checksum byte: define UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
    parameter int AB           = 11,
    parameter int DB           = 16,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    uart_program_loader_if.master pm,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE} ld_state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          byte_valid, byte_valid_n;
    logic          stop_err;

    ld_state_t     ld_state, ld_state_n;
    logic [7:0]    hi_byte;
    logic [AB-1:0] words_left;
    logic [AB-1:0] count_rx;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]    chk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= R_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            byte_valid <= byte_valid_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        clk_cnt_n    = clk_cnt + 1'b1;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        byte_valid_n = 1'b0;
        stop_err     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                clk_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = R_START;
                    bit_cnt_n  = '0;
                end
            end
            R_START: if (clk_cnt == HALF_LAST) begin
                clk_cnt_n  = '0;
                rx_state_n = rx_sync ? R_IDLE : R_DATA;
            end
            R_DATA: if (clk_cnt == BIT_LAST) begin
                clk_cnt_n = '0;
                shift_n   = {rx_sync, shift[7:1]};
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) rx_state_n = R_STOP;
            end
            R_STOP: if (clk_cnt == BIT_LAST) begin
                clk_cnt_n = '0;
                if (rx_sync) begin
                    byte_valid_n = 1'b1;
                    rx_state_n   = R_IDLE;
                end else begin
                    stop_err   = 1'b1;
                    rx_state_n = R_WAIT;
                end
            end
            // Line held low after a bad stop bit: resync only once it returns high.
            R_WAIT: begin
                clk_cnt_n = '0;
                if (rx_sync) rx_state_n = R_IDLE;
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    assign count_rx = AB'({hi_byte, shift});

    always_ff @(posedge clk) begin
        if (reset) ld_state <= S_CNT_HI;
        else       ld_state <= ld_state_n;
    end

    always_comb begin
        ld_state_n = ld_state;
        if (byte_valid) begin
            case (ld_state)
                S_CNT_HI:  ld_state_n = S_CNT_LO;
`ifdef UART_LOADER_CHECKSUM_EN
                S_CNT_LO:  ld_state_n = (count_rx == '0) ? S_CHK : S_DATA_HI;
                S_DATA_LO: ld_state_n = (words_left == AB'(1)) ? S_CHK : S_DATA_HI;
                S_CHK:     ld_state_n = (chk == shift) ? S_DONE : S_CNT_HI;
`else
                S_CNT_LO:  ld_state_n = (count_rx == '0) ? S_DONE : S_DATA_HI;
                S_DATA_LO: ld_state_n = (words_left == AB'(1)) ? S_DONE : S_DATA_HI;
`endif
                S_DATA_HI: ld_state_n = S_DATA_LO;
                default:   ld_state_n = ld_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte     <= '0;
            words_left  <= '0;
            pm.pm_we    <= 1'b0;
            pm.pm_addr  <= '0;
            pm.pm_wdata <= '0;
            frame_err   <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            chk         <= '0;
`endif
        end else begin
            pm.pm_we <= 1'b0;
            if (pm.pm_we) pm.pm_addr <= pm.pm_addr + 1'b1;
            if (stop_err) frame_err <= 1'b1;
            if (byte_valid) begin
                case (ld_state)
                    S_CNT_HI: hi_byte <= shift;
                    S_CNT_LO: begin
                        words_left <= count_rx;
`ifdef UART_LOADER_CHECKSUM_EN
                        chk        <= '0;
`endif
                    end
                    S_DATA_HI: begin
                        hi_byte <= shift;
`ifdef UART_LOADER_CHECKSUM_EN
                        chk     <= chk ^ shift;
`endif
                    end
                    S_DATA_LO: begin
                        pm.pm_we    <= 1'b1;
                        pm.pm_wdata <= DB'({hi_byte, shift});
                        words_left  <= words_left - 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        chk         <= chk ^ shift;
`endif
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    // Bad image: rewind so the host can resend from the header.
                    S_CHK: if (chk != shift) begin
                        frame_err  <= 1'b1;
                        pm.pm_addr <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign done     = (ld_state == S_DONE);
    assign cpu_hold = !done;
    assign busy     = (ld_state == S_DATA_HI) || (ld_state == S_DATA_LO) || (ld_state == S_CHK);
endmodule
